serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Latency: n/a (wires only); one operation takes WIDTH+2 clocks end to end.
// Backpressure: none; the requester watches busy and start is ignored while busy.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  // Requester side: launches operations and consumes results.
  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, sum, carry_out, overflow
  );

  // Adder side.
  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one 1-bit full-adder cell, LSB first, registered carry.
// Latency: start edge E0, bits on E1..E(WIDTH), done pulse after E(WIDTH); WIDTH+2 edges per op.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  serial_adder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold WIDTH-1.
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;     // operand A, shifted right each bit
  logic [WIDTH-1:0] b_q,     b_d;     // operand B (pre-inverted for subtract)
  logic             c_q,     c_d;     // carry into the bit currently processed
  logic [WIDTH-1:0] acc_q,   acc_d;   // working sum, filled from the MSB end
  logic [WIDTH-1:0] sum_q,   sum_d;   // published result
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic fa_s;
  logic fa_c;
  logic last_bit;
  logic accept;

  // The single full-adder cell working on the LSBs of the shift registers.
  assign fa_s     = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign last_bit = (cnt_q == LAST);
  assign accept   = (state_q == IDLE) && bus.start;

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last bit, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load operands on accept, one cell step per RUN cycle, publish on the last bit.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    acc_d  = acc_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;

    if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      a_d   = bus.a_in;
      b_d   = bus.sub ? ~bus.b_in : bus.b_in;
      c_d   = bus.sub;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_c;
      acc_d = {fa_s, acc_q[WIDTH-1:1]};
      if (last_bit) begin
        // c_q is the carry into the MSB here, fa_c the carry out of it.
        sum_d  = {fa_s, acc_q[WIDTH-1:1]};
        cout_d = fa_c;
        ovf_d  = c_q ^ fa_c;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset also wipes a published result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      acc_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule
